// File: rtl/dspl_pkg.sv
// Shared types and helpers for the display scheduler.
//   state_e  : scheduler FSM states (SHOW drives owner data, GAP blanks the display)
//   NUM_DIG  : digits per display, DIG_W: bits per digit in driver format
//   DIG_OFF  : disabled digit with dp off (dp is active-low)
//   get_dig  : extracts digit idx (0-based, idx 0 = digit 1) from a packed digit bus
package dspl_pkg;

  typedef enum logic [0:0] {SHOW, GAP} state_e;

  localparam int unsigned NUM_DIG = 8;
  localparam int unsigned DIG_W   = 6;
  localparam int unsigned BUS_W   = NUM_DIG * DIG_W;

  // Digit format: bit0 = dp (active-low), bits 4:1 = value, bit5 = enable.
  localparam int unsigned DIG_EN_BIT = 5;
  localparam logic [DIG_W-1:0] DIG_OFF = 6'b000001;

  function automatic logic [DIG_W-1:0] get_dig(input logic [BUS_W-1:0] bus,
                                               input int unsigned idx);
    return bus[idx*DIG_W +: DIG_W];
  endfunction

endpackage

// File: rtl/dspl_blink_gen.sv
// Blink phase generator for the display scheduler.
//   clock, reset : system clock, synchronous active-high reset
//   clr          : restart the blink pattern (counter and phase back to 0)
//   phase        : blink phase that applies to the next clock cycle; 1 = blinking digits off
// The phase output looks one cycle ahead so that the registered digit outputs line up
// with the phase they are shown in.
module dspl_blink_gen #(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic phase
);

  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;
  logic             wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Phase that will be held in the coming cycle.
  assign phase = clr ? 1'b0 : (phase_q ^ wrap);

endmodule

// File: rtl/dspl_sched.sv
// Display scheduler: shares one 8-digit seven-segment driver between three sources.
//   clock, reset       : system clock, synchronous active-high reset
//   src0/1/2_dig [47:0]: packed digits of clock / setting / alert views (digit 1 in [5:0])
//   req [1:0]          : req[0] = source 1 request, req[1] = source 2 request
//   blink_mask [7:0]   : bit i-1 blinks digit i of the current owner
//   gnt [2:0]          : one-hot registered owner, 3'b000 while blanking between owners
//   d1..d8 [5:0]       : registered digits to the driver
// Fixed priority 2 > 1 > 0 with a minimum hold before preemption; every owner change
// inserts GAP_CYCLES blank cycles to avoid ghosting.
module dspl_sched
  import dspl_pkg::*;
#(
  parameter int unsigned MIN_HOLD   = 200_000_000,
  parameter int unsigned GAP_CYCLES = 100_000,
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [BUS_W-1:0]   src0_dig,
  input  logic [BUS_W-1:0]   src1_dig,
  input  logic [BUS_W-1:0]   src2_dig,
  input  logic [1:0]         req,
  input  logic [NUM_DIG-1:0] blink_mask,
  output logic [2:0]         gnt,
  output logic [DIG_W-1:0]   d1,
  output logic [DIG_W-1:0]   d2,
  output logic [DIG_W-1:0]   d3,
  output logic [DIG_W-1:0]   d4,
  output logic [DIG_W-1:0]   d5,
  output logic [DIG_W-1:0]   d6,
  output logic [DIG_W-1:0]   d7,
  output logic [DIG_W-1:0]   d8
);

  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        pending_q, pending_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [1:0]        target;
  logic              owner_req;
  logic              do_switch;
  logic              gap_done;
  logic              phase;

  logic [2:0]        gnt_d;
  logic [BUS_W-1:0]  src_sel;
  logic [DIG_W-1:0]  dig_d [NUM_DIG];
  logic [DIG_W-1:0]  dig_q [NUM_DIG];

  // Highest active requester; source 0 is the implicit background.
  always_comb begin
    if (req[1]) begin
      target = 2'd2;
    end else if (req[0]) begin
      target = 2'd1;
    end else begin
      target = 2'd0;
    end
  end

  always_comb begin
    case (owner_q)
      2'd1:    owner_req = req[0];
      2'd2:    owner_req = req[1];
      default: owner_req = 1'b1;
    endcase
  end

  // A released owner leaves at once; preemption by a higher source waits for the hold.
  assign do_switch = (state_q == SHOW) && (target != owner_q) &&
                     (!owner_req || ((target > owner_q) && (hold_q == HOLD_MAX)));
  assign gap_done  = (state_q == GAP) && (gap_q == GAP_LAST);

  dspl_blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clock(clock),
    .reset(reset),
    .clr  (gap_done),
    .phase(phase)
  );

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SHOW;
      owner_q   <= 2'd0;
      pending_q <= 2'd0;
      hold_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    case (state_q)
      SHOW: begin
        if (do_switch) begin
          state_d   = GAP;
          pending_d = target;
          gap_d     = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      GAP: begin
        // Requests are not looked at here; SHOW re-evaluates them.
        if (gap_done) begin
          state_d = SHOW;
          owner_d = pending_q;
          hold_d  = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  // Output logic, computed for the coming cycle so gnt and data change together.
  always_comb begin
    gnt_d   = 3'b000;
    src_sel = src0_dig;
    for (int unsigned i = 0; i < NUM_DIG; i++) begin
      dig_d[i] = DIG_OFF;
    end
    if (state_d == SHOW) begin
      gnt_d = 3'b001 << owner_d;
      case (owner_d)
        2'd1:    src_sel = src1_dig;
        2'd2:    src_sel = src2_dig;
        default: src_sel = src0_dig;
      endcase
      for (int unsigned i = 0; i < NUM_DIG; i++) begin
        dig_d[i] = get_dig(src_sel, i);
        if (blink_mask[i] && phase) begin
          dig_d[i][DIG_EN_BIT] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt <= 3'b001;
      for (int unsigned i = 0; i < NUM_DIG; i++) begin
        dig_q[i] <= DIG_OFF;
      end
    end else begin
      gnt <= gnt_d;
      for (int unsigned i = 0; i < NUM_DIG; i++) begin
        dig_q[i] <= dig_d[i];
      end
    end
  end

  assign d1 = dig_q[0];
  assign d2 = dig_q[1];
  assign d3 = dig_q[2];
  assign d4 = dig_q[3];
  assign d5 = dig_q[4];
  assign d6 = dig_q[5];
  assign d7 = dig_q[6];
  assign d8 = dig_q[7];

endmodule

// File: tb/tb_dspl_sched.sv
// Bench for dspl_sched with short timing parameters. A behavioural model tracks
// owner, time spent showing and remaining blank cycles, and predicts gnt and d1..d8
// after every clock edge. Directed sequences cover the key scenarios, then random
// requests, masks, digit data and occasional resets.
module tb_dspl_sched;

  localparam int unsigned MinHold   = 8;
  localparam int unsigned GapCycles = 3;
  localparam int unsigned BlinkHalf = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] src0, src1, src2;
  logic [1:0]  req;
  logic [7:0]  blink_mask;
  logic [2:0]  gnt;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [47:0] d_bus;

  assign d_bus = {d8, d7, d6, d5, d4, d3, d2, d1};

  always #5 clock = ~clock;

  dspl_sched #(
    .MIN_HOLD  (MinHold),
    .GAP_CYCLES(GapCycles),
    .BLINK_HALF(BlinkHalf)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .src0_dig  (src0),
    .src1_dig  (src1),
    .src2_dig  (src2),
    .req       (req),
    .blink_mask(blink_mask),
    .gnt       (gnt),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .d5        (d5),
    .d6        (d6),
    .d7        (d7),
    .d8        (d8)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: who owns the display, how long it has shown, blanking progress.
  int          m_owner;
  int          m_pending;
  int          m_age;
  int          m_gap_left;
  bit          m_in_gap;
  logic [2:0]  exp_gnt;
  logic [47:0] exp_d;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] rand48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  function automatic logic [47:0] src_of(input int s);
    if (s == 2) return src2;
    if (s == 1) return src1;
    return src0;
  endfunction

  // Digits of source s as seen `age` cycles after it took the display.
  function automatic logic [47:0] show_view(input int s, input int age, input logic [7:0] mask);
    logic [47:0] v;
    bit          dark;
    v    = src_of(s);
    dark = ((age / BlinkHalf) % 2) == 1;
    for (int i = 0; i < 8; i++) begin
      if (dark && mask[i]) v[6*i+5] = 1'b0;
    end
    return v;
  endfunction

  task automatic set_blank();
    exp_gnt = 3'b000;
    exp_d   = {8{6'b000001}};
  endtask

  task automatic set_show();
    exp_gnt = 3'(1 << m_owner);
    exp_d   = show_view(m_owner, m_age, blink_mask);
  endtask

  // Advances the model across one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int tgt;
    bit own_req;
    if (reset) begin
      m_owner  = 0;
      m_in_gap = 0;
      m_age    = 0;
      exp_gnt  = 3'b001;
      exp_d    = {8{6'b000001}};
    end else if (m_in_gap) begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        m_in_gap = 0;
        m_owner  = m_pending;
        m_age    = 0;
        set_show();
      end else begin
        set_blank();
      end
    end else begin
      tgt     = req[1] ? 2 : (req[0] ? 1 : 0);
      own_req = (m_owner == 0) || (m_owner == 1 && req[0]) || (m_owner == 2 && req[1]);
      if (tgt != m_owner && (!own_req || (tgt > m_owner && m_age >= MinHold))) begin
        m_in_gap   = 1;
        m_gap_left = GapCycles;
        m_pending  = tgt;
        set_blank();
      end else begin
        m_age++;
        set_show();
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_eq("gnt", 48'(gnt), 48'(exp_gnt));
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("d%0d", i + 1), 48'(d_bus[6*i +: 6]), 48'(exp_d[6*i +: 6]));
    end
  endtask

  task automatic new_srcs();
    src0 = rand48();
    src1 = rand48();
    src2 = rand48();
  endtask

  task automatic run(input int n, input logic [1:0] r);
    req = r;
    for (int k = 0; k < n; k++) begin
      new_srcs();
      step();
    end
  endtask

  initial begin
    logic [5:0] want_d1;
    reset      = 1'b1;
    req        = 2'b00;
    blink_mask = 8'h01;
    new_srcs();
    src0[5:0]  = 6'b100011;
    for (int k = 0; k < 3; k++) step();
    check_eq("rst_d1_off", 48'(d1), 48'(6'b000001));

    // First cycle out of reset shows source 0.
    reset = 1'b0;
    step();
    check_eq("rst_gnt", 48'(gnt), 48'(3'b001));
    check_eq("rst_d1_src0", 48'(d1), 48'(6'b100011));

    // Hold saturates, then source 1 requests: blank gap, then source 1.
    run(10, 2'b00);
    run(8, 2'b01);
    check_eq("own1", 48'(gnt), 48'(3'b010));

    // Source 2 arrives mid-hold: waits for the hold, then takes over.
    run(20, 2'b11);
    check_eq("own2", 48'(gnt), 48'(3'b100));

    // Source 2 leaves as source 1 is requesting: goes to 1 and stays there.
    run(40, 2'b01);
    check_eq("stay_own1", 48'(gnt), 48'(3'b010));

    // Reset in the middle of a gap.
    run(2, 2'b00);
    check_eq("in_gap", 48'(gnt), 48'(3'b000));
    reset = 1'b1;
    run(1, 2'b00);
    check_eq("gap_rst_gnt", 48'(gnt), 48'(3'b001));
    check_eq("gap_rst_d1", 48'(d1), 48'(6'b000001));
    reset = 1'b0;
    new_srcs();
    want_d1 = src0[5:0];
    step();
    check_eq("gap_rst_src0", 48'(d1), 48'(want_d1));

    // Random traffic with slowly changing requests.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(299) == 0);
      if ($urandom_range(5) == 0) req = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) blink_mask = 8'($urandom());
      new_srcs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
